uart_tx: RTL
============

# uart_tx

Buffered 8N1 UART transmitter, the send-side counterpart of the accelerator's UART receiver. It accepts bytes from the host-side logic into a small FIFO and serialises them LSB-first on `o_Tx_Serial`, using the same `CLKS_PER_BIT` baud convention as the receiver. A `transmit` gate lets the controller hold frames back without losing buffered data.

## Interface
- `CLKS_PER_BIT`, 10416: clocks per serial bit, equal to (i_Clock freq)/(baud). Legal range 2..262143.
- `FIFO_AW`, 2: FIFO address width. Depth is FIFO_DEPTH = 2^FIFO_AW (default 4).
- `i_Clock`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `transmit`  in  1  permission to start a new frame; it is sampled only when a frame could start.
- `i_Tx_DV`  in  1  write strobe; a byte is accepted on an edge where `i_Tx_DV && o_Tx_Ready`.
- `i_Tx_Byte`  in  8  byte to enqueue.
- `o_Tx_Ready`  out  1  FIFO not full (count < FIFO_DEPTH), combinational from the count.
- `o_Tx_Serial`  out  1  serial line, registered; idles high.
- `o_Tx_Active`  out  1  high while a frame (start, data, stop) is on the line.
- `o_Tx_Done`  out  1  one-cycle pulse after each frame's stop bit.
- `o_Fifo_Count`  out  FIFO_AW+1  number of buffered, unsent bytes.

## Operation
- FIFO: circular buffer with FIFO_AW-bit read/write pointers that wrap modulo FIFO_DEPTH, plus a FIFO_AW+1-bit count.
  - Write when full: dropped silently; pointers and count are unchanged.
  - Pop when empty: never happens, because a frame starts only when count > 0.
  - Write and pop on the same edge: both occur and the count is unchanged. When full, the write is still rejected because `o_Tx_Ready` is already low.
- Internal state: 18-bit clock counter, 3-bit bit index, 8-bit shift/hold register, 3-bit state register.
- State machine:
  - `s_IDLE`: line high, Active 0. If `transmit && count>0`: pop the head into the hold register, drive the line low, set Active=1, clear the counter, go to `s_TX_START_BIT`. Otherwise stay.
  - `s_TX_START_BIT`: line low for CLKS_PER_BIT cycles (counter 0..CLKS_PER_BIT-1). At terminal count: clear the counter, set bit index 0, drive hold[0], go to `s_TX_DATA_BITS`.
  - `s_TX_DATA_BITS`: drive hold[bit index] for CLKS_PER_BIT cycles. At terminal count: if index<7, increment the index and drive the next bit; else drive 1 and go to `s_TX_STOP_BIT`.
  - `s_TX_STOP_BIT`: line high for CLKS_PER_BIT cycles. At terminal count: Active<=0, Done<=1, go to `s_CLEANUP`.
  - `s_CLEANUP`: one cycle, line high, Done=1. Next edge: Done<=0. If `transmit && count>0`, pop and go to `s_TX_START_BIT` (line low); else go to `s_IDLE`.
  - Unused encodings: go to `s_IDLE` with the line high.
- Deasserting `transmit` mid-frame does not affect the current frame; it only blocks the next one. Buffered bytes are retained.
- The hold register is loaded only at pop, so FIFO writes during a frame never corrupt the byte on the line.

## Timing
- Reset values (applied asynchronously):
  - Outputs: `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, `o_Fifo_Count`=0, `o_Tx_Ready`=1.
  - Internal: state `s_IDLE`; counter, index and pointers all 0.
- Reset mid-frame: the line goes high immediately, the frame is aborted, all buffered bytes are discarded, and no Done pulse is produced.
- Write-to-line latency: a byte written at edge N into an empty FIFO, in `s_IDLE` with `transmit`=1, is popped at edge N+1. The line is low from edge N+1.
- Frame duration: exactly 10*CLKS_PER_BIT cycles from the first low cycle to the end of the stop bit.
  - Done is high for the single following cycle.
- Back-to-back frames: exactly one extra high cycle (`s_CLEANUP`) between a stop bit and the next start bit.
- `o_Fifo_Count` and `o_Tx_Ready` update on the edge after the write or pop.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> serial=1, Active=0, Done=0, count=0, Ready=1, all before the next clock edge.
- Single byte, CLKS_PER_BIT=4: write 0xA5 with transmit=1 -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - Active is high for 40 cycles, then Done pulses for 1 cycle.
  - count returns to 0 one cycle after the write.
- Fill and overflow:
  - With transmit=0, write 0x00, 0xFF, 0x55, 0x3C, 0x99 -> count=4, Ready=0 after the 4th write, and 0x99 is dropped.
  - Then raise transmit -> four frames in order, each separated by exactly 1 high cycle, and count ends at 0.
- Gating: buffer 2 bytes, drop transmit during the first frame's data bits -> the first frame completes with a Done pulse, the line stays high, and count=1.
  - Raise transmit again -> the second frame starts on the next edge.
- Concurrent write/pop: count=1 in `s_IDLE`, write 0x42 on the same edge as the pop -> count stays 1, and 0x42 is sent next.
- Reset mid-frame: assert reset during bit 3 with 2 bytes buffered -> the line goes high immediately, count=0, and no Done pulse.
  - After release, the line stays idle until a new write.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter. Bytes are queued in a small
// circular FIFO and sent LSB-first, framed by one start bit and one stop bit.
// Each bit is held for CLKS_PER_BIT clocks.
//
// Handshake: i_Tx_DV is a write strobe qualified by o_Tx_Ready. A byte is
// taken on any rising edge where i_Tx_DV && o_Tx_Ready. o_Tx_Ready is low only
// when the FIFO is full; a strobe that sees it low is dropped. No
// acknowledgement or back-pressure beyond o_Tx_Ready exists.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_AW      = 2
) (
  input  logic               i_Clock,
  input  logic               reset,
  input  logic               transmit,
  input  logic               i_Tx_DV,
  input  logic [7:0]         i_Tx_Byte,
  output logic               o_Tx_Ready,
  output logic               o_Tx_Serial,
  output logic               o_Tx_Active,
  output logic               o_Tx_Done,
  output logic [FIFO_AW:0]   o_Fifo_Count
);

  localparam int                FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [17:0]       BIT_LAST   = 18'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]  COUNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_TX_START_BIT = 3'd1,
    s_TX_DATA_BITS = 3'd2,
    s_TX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               wr_en;
  logic               pop;

  // Transmit datapath and FSM state
  state_t      r_state, n_state;
  logic [17:0] r_clk_count, n_clk_count;
  logic [2:0]  r_bit_index, n_bit_index;
  logic [7:0]  r_hold, n_hold;
  logic        r_serial, n_serial;
  logic        r_active, n_active;
  logic        r_done, n_done;
  logic        start_ok;

  assign o_Tx_Ready   = (r_count < COUNT_FULL);
  assign o_Fifo_Count = r_count;
  assign o_Tx_Serial  = r_serial;
  assign o_Tx_Active  = r_active;
  assign o_Tx_Done    = r_done;

  assign wr_en    = i_Tx_DV && o_Tx_Ready;
  // A frame may start only from a registered non-zero count, so a pop can
  // never hit an empty FIFO even when a write lands on the same edge.
  assign start_ok = transmit && (r_count != '0);

  // FIFO storage: written on accepted strobes, contents need no reset
  always_ff @(posedge i_Clock) begin
    if (wr_en) fifo_mem[r_wr_ptr] <= i_Tx_Byte;
  end

  // FIFO pointers and occupancy count; write and pop may coincide
  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (pop)   r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_count <= r_count + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(pop);
    end
  end

  // FSM state and registered line outputs
  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      r_state     <= s_IDLE;
      r_clk_count <= '0;
      r_bit_index <= '0;
      r_hold      <= '0;
      r_serial    <= 1'b1;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= n_state;
      r_clk_count <= n_clk_count;
      r_bit_index <= n_bit_index;
      r_hold      <= n_hold;
      r_serial    <= n_serial;
      r_active    <= n_active;
      r_done      <= n_done;
    end
  end

  // Next-state logic: bit timing, framing and FIFO pop decision
  always_comb begin
    n_state     = r_state;
    n_clk_count = r_clk_count;
    n_bit_index = r_bit_index;
    n_hold      = r_hold;
    n_serial    = r_serial;
    n_active    = r_active;
    n_done      = r_done;
    pop         = 1'b0;

    case (r_state)
      s_IDLE: begin
        n_serial = 1'b1;
        n_active = 1'b0;
        n_done   = 1'b0;
        if (start_ok) begin
          pop         = 1'b1;
          n_hold      = fifo_mem[r_rd_ptr];
          n_serial    = 1'b0;
          n_active    = 1'b1;
          n_clk_count = '0;
          n_state     = s_TX_START_BIT;
        end
      end

      s_TX_START_BIT: begin
        if (r_clk_count == BIT_LAST) begin
          n_clk_count = '0;
          n_bit_index = '0;
          n_serial    = r_hold[0];
          n_state     = s_TX_DATA_BITS;
        end else begin
          n_clk_count = r_clk_count + 18'd1;
        end
      end

      s_TX_DATA_BITS: begin
        if (r_clk_count == BIT_LAST) begin
          n_clk_count = '0;
          if (r_bit_index < 3'd7) begin
            n_bit_index = r_bit_index + 3'd1;
            n_serial    = r_hold[n_bit_index];
          end else begin
            n_serial = 1'b1;
            n_state  = s_TX_STOP_BIT;
          end
        end else begin
          n_clk_count = r_clk_count + 18'd1;
        end
      end

      s_TX_STOP_BIT: begin
        if (r_clk_count == BIT_LAST) begin
          n_clk_count = '0;
          n_active    = 1'b0;
          n_done      = 1'b1;
          n_state     = s_CLEANUP;
        end else begin
          n_clk_count = r_clk_count + 18'd1;
        end
      end

      s_CLEANUP: begin
        n_done = 1'b0;
        if (start_ok) begin
          pop         = 1'b1;
          n_hold      = fifo_mem[r_rd_ptr];
          n_serial    = 1'b0;
          n_active    = 1'b1;
          n_clk_count = '0;
          n_state     = s_TX_START_BIT;
        end else begin
          n_serial = 1'b1;
          n_state  = s_IDLE;
        end
      end

      default: begin
        n_serial = 1'b1;
        n_active = 1'b0;
        n_done   = 1'b0;
        n_state  = s_IDLE;
      end
    endcase
  end

endmodule
